instr_fetch_unit: RTL
=====================

// Module: instr_fetch_unit
// PURPOSE
//   Fetch stage of the single-clock schoolRISCV core. Owns the PC, drives the word
//   address into the combinational instruction ROM, and captures each returned word
//   with its PC into a small FIFO. The FIFO feeds decode over a valid/ready handshake.
//   Handles control-flow redirects from execute by flushing the FIFO.
// PARAMETERS
//   RESET_PC   32'h0000_0000  byte PC loaded on reset
//   ROM_SIZE   64             ROM depth in 32-bit words; word indices >= ROM_SIZE fault
//   DEPTH      2              FIFO entries (power of 2, >= 2)
// PORTS
//   clk             in   1   clock, rising edge
//   rst             in   1   synchronous, active-high reset
//   imem_addr       out  32  ROM word index = {2'b00, pc[31:2]}
//   imem_rdata      in   32  ROM data, combinational from imem_addr in the same cycle
//   redirect_valid  in   1   redirect request from execute (branch/jump taken)
//   redirect_pc     in   32  byte target; bits [1:0] ignored (treated as 0)
//   out_valid       out  1   FIFO head holds a valid entry
//   out_ready       in   1   decode accepts the head this cycle
//   out_instr       out  32  head instruction word
//   out_pc          out  32  head byte PC
//   out_fault       out  1   head was fetched from word index >= ROM_SIZE
// BEHAVIOUR
//   Reset (clk edge with rst=1): pc<=RESET_PC with bits [1:0] forced to 0; FIFO emptied.
//     out_valid=0, out_instr=0, out_pc=0, out_fault=0 while empty.
//   pop  = out_valid & out_ready. Head and count advance at the next edge.
//   push = !redirect_valid & (count<DEPTH | pop). Full with simultaneous pop pushes.
//   On push: the entry {imem_rdata, pc, fault} is written at the tail, and pc<=pc+4
//     (mod 2^32, wraps silently).
//   If pc[31:2] >= ROM_SIZE: fault=1 and the stored instr is 32'h0000_0013 (NOP),
//     not imem_rdata.
//   Latency: ROM read and capture take the same cycle. An entry is visible on out_*
//     the cycle after its push. Empty FIFO gives out_valid=0 for exactly that cycle.
//   Throughput: 1 instr/cycle sustained while out_ready=1.
//   Stall (out_ready=0): FIFO fills to DEPTH, then push=0 and pc holds. Head outputs
//     are stable while out_valid=1 & out_ready=0.
//   Redirect (redirect_valid=1 at an edge):
//     - pc<={redirect_pc[31:2],2'b00}
//     - FIFO cleared: count<=0, and the head is dropped even if pop=1 that cycle
//     - no push that cycle
//     - first target entry is pushed the next cycle and shows out_valid the cycle after
//     - back-to-back redirects: the last one wins, and out_valid stays 0 throughout
//   rst has priority over redirect_valid and the handshake; reset mid-stall discards
//     all entries.
//   Outputs when out_valid=0: out_instr=0, out_pc=0, out_fault=0 (no stale data).
//   FIFO: DEPTH-entry circular buffer with rd/wr pointers that wrap at DEPTH, and a
//     count register of $clog2(DEPTH)+1 bits. count never exceeds DEPTH.
//   imem_addr is always driven from pc, including during stall and reset.
// TESTING
//   1 Reset, RESET_PC=0, out_ready=1, ROM[i]=i+1 -> out_valid from cycle 2;
//     out_pc 0,4,8,... with out_instr 1,2,3,... with no gaps.
//   2 out_ready=0 for 5 cycles after cycle 2 -> count=2, pc frozen at 8, head
//     pc=0/instr=1 stable; release -> 0,4,8 delivered in order with no drop or duplicate.
//   3 redirect_valid=1, redirect_pc=32'h23 while FIFO full -> next cycle out_valid=0;
//     cycle after, out_pc=32'h20 with out_instr=ROM[8].
//   4 redirect to 32'h0FC with ROM_SIZE=64 -> out_pc 0xFC with fault=0 and
//     instr=ROM[63]; then 0x100 with fault=1 and instr=32'h13.
//   5 redirect_valid=1 and pop in the same cycle, plus two consecutive redirects
//     (0x40 then 0x80) -> no entry from the old or 0x40 path is ever valid; first
//     out_pc=0x80.
//   6 Assert rst mid-stream with FIFO holding 2 entries -> next cycle out_valid=0 and
//     imem_addr=RESET_PC>>2; restart matches scenario 1.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, reads the combinational instruction ROM and queues
// {instr, pc, fault} entries in a small FIFO that feeds decode over valid/ready.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ROM_SIZE = 64,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        out_fault
);

    localparam int          PTR_W     = $clog2(DEPTH);
    localparam int          CNT_W     = PTR_W + 1;
    localparam logic [31:0] ROM_WORDS = 32'(ROM_SIZE);
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [31:0]      pc_q, pc_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [31:0] instr_mem [DEPTH];
    logic [31:0] pc_mem    [DEPTH];
    logic        fault_mem [DEPTH];

    logic        push;
    logic        pop;
    logic [31:0] word_idx;
    logic        fetch_fault;
    logic [31:0] fetch_instr;

    // Only the word-aligned part of a redirect target is meaningful.
    logic unused_redirect_lsb;
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    assign word_idx    = {2'b00, pc_q[31:2]};
    assign imem_addr   = word_idx;
    assign fetch_fault = (word_idx >= ROM_WORDS);
    assign fetch_instr = fetch_fault ? NOP_INSTR : imem_rdata;

    assign out_valid = (count_q != '0);
    assign pop       = out_valid & out_ready;
    // A full FIFO still accepts a new word when the head leaves in the same cycle.
    assign push      = !redirect_valid && ((count_q < FULL_COUNT) || pop);

    always_comb begin
        pc_d     = pc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (redirect_valid) begin
            pc_d     = {redirect_pc[31:2], 2'b00};
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                pc_d     = pc_q + 32'd4;
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= {RESET_PC[31:2], 2'b00};
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            pc_q     <= pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset: entries are only exposed while count is non-zero.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr_q] <= fetch_instr;
            pc_mem[wr_ptr_q]    <= pc_q;
            fault_mem[wr_ptr_q] <= fetch_fault;
        end
    end

    assign out_instr = out_valid ? instr_mem[rd_ptr_q] : 32'h0;
    assign out_pc    = out_valid ? pc_mem[rd_ptr_q]    : 32'h0;
    assign out_fault = out_valid ? fault_mem[rd_ptr_q] : 1'b0;

endmodule
